// File: rtl/axi_full_slave_pkg.sv
// axi_full_slave_pkg: shared burst/response encodings and FSM state types
// for the AXI4 full memory slave.
//   BURST_*   : AxBURST encodings (FIXED, INCR, WRAP)
//   RESP_*    : xRESP encodings (OKAY, SLVERR)
//   w_state_t : write channel FSM states
//   r_state_t : read channel FSM states
package axi_full_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next-word-index and burst error logic.
// Ports:
//   i_idx      : current word index
//   i_len      : burst length minus 1
//   i_burst    : burst type
//   o_next_idx : index of the following beat (modulo RAM depth)
//   o_err      : burst is illegal and must be answered with SLVERR
// Optional feature: AXI_SLAVE_WRAP_EN enables WRAP addressing; without it
// WRAP bursts step as INCR and are always flagged as errors.
module axi_burst_addr_gen
    import axi_full_slave_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] i_idx,
    input  logic [7:0]       i_len,
    input  logic [1:0]       i_burst,
    output logic [IDX_W-1:0] o_next_idx,
    output logic             o_err
);

    logic [IDX_W-1:0] w_inc;
    logic             w_wrap;

    assign w_inc = i_idx + IDX_W'(1);

`ifdef AXI_SLAVE_WRAP_EN
    logic             w_len_ok;
    logic [IDX_W-1:0] w_mask;

    assign w_len_ok = (i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15);
    // The block is len+1 words, so len itself is the in-block offset mask.
    assign w_mask     = i_len[IDX_W-1:0];
    assign w_wrap     = (i_burst == BURST_WRAP) && w_len_ok;
    assign o_next_idx = (i_burst == BURST_FIXED) ? i_idx :
                        w_wrap ? ((i_idx & ~w_mask) | (w_inc & w_mask)) : w_inc;
`else
    logic w_unused_len;

    assign w_unused_len = ^i_len;
    assign w_wrap       = 1'b0;
    assign o_next_idx   = (i_burst == BURST_FIXED) ? i_idx : w_inc;
`endif

    // Reserved type and any WRAP that is not honoured fall back to INCR with SLVERR.
    assign o_err = (i_burst == 2'b11) || ((i_burst == BURST_WRAP) && !w_wrap);

endmodule

// File: rtl/axi_full_slave_mem.sv
// axi_full_slave_mem: AXI4 full memory slave, one write burst and one read
// burst in flight on independent channels, word-addressed internal RAM.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET        : clock, synchronous active-high reset
//   S_AXI_AW{ADDR,LEN,BURST,VALID,READY} : write address channel
//   S_AXI_W{DATA,STRB,LAST,VALID,READY}  : write data channel
//   S_AXI_B{RESP,VALID,READY}        : write response channel
//   S_AXI_AR{ADDR,LEN,BURST,VALID,READY} : read address channel
//   S_AXI_R{DATA,RESP,LAST,VALID,READY}  : read data channel
// Optional feature: AXI_SLAVE_WRAP_EN (see axi_burst_addr_gen).
module axi_full_slave_mem
    import axi_full_slave_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [DEPTH];

    w_state_t                      r_wstate;
    logic [IDX_W-1:0]              r_widx;
    logic [7:0]                    r_wlen;
    logic [1:0]                    r_wburst;
    logic [7:0]                    r_wcnt;
    logic                          r_werr;
    logic                          r_awready;
    logic                          r_wready;
    logic                          r_bvalid;
    logic [1:0]                    r_bresp;

    r_state_t                      r_rstate;
    logic [IDX_W-1:0]              r_ridx;
    logic [7:0]                    r_rlen;
    logic [1:0]                    r_rburst;
    logic [7:0]                    r_rcnt;
    logic                          r_arready;
    logic                          r_rvalid;
    logic                          r_rlast;
    logic [1:0]                    r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic [IDX_W-1:0]              w_wnext;
    logic                          w_wgen_err;
    logic                          w_wbeat;
    logic                          w_wlast_beat;
    logic                          w_wlast_bad;
    logic [IDX_W-1:0]              w_aridx;
    logic [IDX_W-1:0]              w_rgen_idx;
    logic [7:0]                    w_rgen_len;
    logic [1:0]                    w_rgen_burst;
    logic [IDX_W-1:0]              w_rnext;
    logic                          w_rgen_err;
    logic                          w_unused_addr;

    assign w_unused_addr = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RLAST   = r_rlast;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;

    // ---------------- write channel ----------------
    assign w_wbeat      = r_wready && S_AXI_WVALID && !S_AXI_ARESET;
    assign w_wlast_beat = (r_wcnt == r_wlen);
    assign w_wlast_bad  = (S_AXI_WLAST != w_wlast_beat);

    axi_burst_addr_gen #(.IDX_W(IDX_W)) u_wgen (
        .i_idx      (r_widx),
        .i_len      (r_wlen),
        .i_burst    (r_wburst),
        .o_next_idx (w_wnext),
        .o_err      (w_wgen_err)
    );

    // RAM is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_wbeat) begin
            for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++) begin
                if (S_AXI_WSTRB[b]) r_mem[r_widx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (r_awready && S_AXI_AWVALID) begin
                        r_widx    <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                        r_wlen    <= S_AXI_AWLEN;
                        r_wburst  <= S_AXI_AWBURST;
                        r_wcnt    <= 8'd0;
                        r_werr    <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    // Beat count alone ends the burst; WLAST only feeds the error flag.
                    if (S_AXI_WVALID) begin
                        r_widx <= w_wnext;
                        r_wcnt <= r_wcnt + 8'd1;
                        if (w_wlast_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || w_wlast_bad || w_wgen_err) ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end else begin
                            r_werr <= r_werr || w_wlast_bad;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= RESP_OKAY;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    // While idle the generator evaluates the incoming AR request so its error
    // flag is known on the handshake edge; during the burst it tracks the
    // latched burst.
    assign w_aridx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_rgen_idx   = (r_rstate == R_IDLE) ? w_aridx : r_ridx;
    assign w_rgen_len   = (r_rstate == R_IDLE) ? S_AXI_ARLEN : r_rlen;
    assign w_rgen_burst = (r_rstate == R_IDLE) ? S_AXI_ARBURST : r_rburst;

    axi_burst_addr_gen #(.IDX_W(IDX_W)) u_rgen (
        .i_idx      (w_rgen_idx),
        .i_len      (w_rgen_len),
        .i_burst    (w_rgen_burst),
        .o_next_idx (w_rnext),
        .o_err      (w_rgen_err)
    );

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (r_arready && S_AXI_ARVALID) begin
                        r_ridx    <= w_aridx;
                        r_rlen    <= S_AXI_ARLEN;
                        r_rburst  <= S_AXI_ARBURST;
                        r_rcnt    <= 8'd0;
                        r_rdata   <= r_mem[w_aridx];
                        r_rlast   <= (S_AXI_ARLEN == 8'd0);
                        r_rresp   <= w_rgen_err ? RESP_SLVERR : RESP_OKAY;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_rresp   <= RESP_OKAY;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_ridx  <= w_rnext;
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                            r_rdata <= r_mem[w_rnext];
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule
